// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war: an LFSR is compared against a difficulty threshold once per tick, and a one-cycle press is issued on a hit.
// Press lands on the edge that ends a tick cycle; a cooldown then ignores MIN_GAP ticks. No backpressure, and freeze or ~enable parks the FSM in IDLE.
module cpu_player #(
    parameter int TICK_CYCLES = 32768,
    parameter int MIN_GAP     = 2
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_freeze,
    input  logic [9:0] i_difficulty,
    output logic       o_press,
    output logic [9:0] o_lfsr_q
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_INIT   = GW'(MIN_GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COOLDOWN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [9:0]    r_lfsr;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_nxt;
    logic          r_press;
    logic          w_press_nxt;

    logic          w_running;
    logic          w_tick;
    logic          w_hit;
    logic [9:0]    w_lfsr_nxt;

    assign w_running  = i_enable & ~i_freeze;
    assign w_tick     = w_running & (r_count == LAST_COUNT);
    assign w_hit      = (i_difficulty > r_lfsr);
    // XNOR feedback keeps all-zeros legal; all-ones is the unreachable lockup.
    assign w_lfsr_nxt = {r_lfsr[8:0], ~(r_lfsr[9] ^ r_lfsr[6])};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (!w_running || (r_count == LAST_COUNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr <= '0;
        end else if (w_tick) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_press <= w_press_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_press_nxt = 1'b0;
        if (!w_running) begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_tick && w_hit) begin
                        w_press_nxt = 1'b1;
                        w_gap_nxt   = GAP_INIT;
                        w_state_nxt = S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    // The tick that drains the gap re-arms but is not itself evaluated.
                    if (r_gap == '0) begin
                        w_state_nxt = S_ARMED;
                    end else if (w_tick) begin
                        w_gap_nxt = r_gap - GW'(1);
                        if (r_gap == GW'(1)) begin
                            w_state_nxt = S_ARMED;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                end
            endcase
        end
    end

    assign o_press  = r_press;
    assign o_lfsr_q = r_lfsr;

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Computer opponent for the tug-of-war game; it generates the "press" stimulus that the playfield lights consume.
- Its press output drives the playfield's R input in place of the debounced KEY[0] path. The human keeps the L side.
- Press timing is pseudo-random: a 10-bit LFSR is compared against a switch-selected difficulty once per game tick. Presses are gated by a cooldown FSM so the opponent cannot press on consecutive ticks.

Parameters:
- TICK_CYCLES, 32768: clock cycles per decision tick. Benches override it to 4.
- MIN_GAP, 2: number of decision ticks ignored after each press.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset; clears all state immediately
- enable  in  1  game running (SW[9])
- freeze  in  1  game over / victory asserted; has priority over enable
- difficulty  in  10  unsigned threshold; a larger value means a faster opponent
- press  out  1  single-cycle press pulse to the playfield
- lfsr_q  out  10  current LFSR state, exposed for debug and verification

Behaviour:
- Reset (async, high): tick counter=0, lfsr_q=0, cooldown counter=0, state=IDLE, press=0. These values are forced while reset is held.
- running = enable & ~freeze.
- Tick counter: while running, increments each clock and wraps from TICK_CYCLES-1 to 0. tick = running & (count==TICK_CYCLES-1). When not running, the counter clears to 0 on the next edge.
- LFSR: Fibonacci with XNOR feedback; next = {q[8:0], ~(q[9]^q[6])}.
  - Steps only on tick, holds otherwise.
  - Sequence from reset: 0,1,3,7,15,31,63,127,254,...
  - All-ones (1023) is the lockup state and is never reached from 0.
- Decision: at a tick, hit = (difficulty > lfsr_q), using the pre-step LFSR value, unsigned 10-bit compare.
- FSM states: IDLE, ARMED, COOLDOWN.
  - IDLE: when running, go to ARMED on the next edge. No decisions are made in IDLE.
  - ARMED: on tick & hit, press<=1 for exactly one cycle, gap<=MIN_GAP, go to COOLDOWN. On tick & ~hit, stay in ARMED.
  - COOLDOWN: on each tick, gap decrements and no press is issued. At the tick where gap reaches 0, go to ARMED; that tick itself is not evaluated. If MIN_GAP=0, return to ARMED on the next edge without consuming a tick.
  - Any state with ~running: go to IDLE and clear gap; press<=0. LFSR and lfsr_q hold their values.
- press: registered. It rises on the edge that ends the tick cycle and falls on the following edge. It is never high for two consecutive cycles.
- Latency: press is high TICK_CYCLES cycles after the first running cycle following IDLE→ARMED, given a hit.
- Boundaries:
  - difficulty=0: never presses.
  - difficulty=1023: presses at every evaluated tick, i.e. one press per MIN_GAP+1 ticks.
  - freeze and enable both high: freeze wins.
  - Freeze coinciding with tick: no press, no LFSR step.
  - Reset mid-pulse: press drops asynchronously.

Test Plan:
- Reset, enable=1, freeze=0, difficulty=2, TICK_CYCLES=4, MIN_GAP=2 -> one press pulse, 1 cycle wide, on the first tick (pre-step lfsr_q=0). No further press through lfsr_q=127. lfsr_q steps 0→1→3→7 at each tick.
- difficulty=1023, same parameters -> presses at ticks 1, 4, 7, 10. Pulses are exactly 12 cycles apart. Ticks 2, 3, 5, 6 produce no press. lfsr_q still steps at every tick.
- difficulty=0, 40 ticks -> press stays 0 throughout. lfsr_q follows 0,1,3,7,15,31,63,127,254,...
- difficulty=1023; freeze=1 for 10 cycles right after the first press (mid-cooldown), then freeze=0 -> no press and lfsr_q frozen during freeze. The cooldown is cleared, so the first tick after resuming (4 cycles after re-arming) presses.
- Assert reset asynchronously in the cycle press=1 -> press, lfsr_q and count read 0 before the next clock edge. After release the sequence restarts at lfsr_q=0.
- enable=1 and freeze=1 together for 20 cycles, difficulty=1023 -> no press and lfsr_q unchanged.
